dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-ported word-addressed data memory.
- Port 0 is the data-cache/MEM-stage port; port 1 is the instruction-fetch refill port.
- Grants one access at a time with round-robin priority, drives the memory read/write/busywait handshake, returns read data and a busywait release to the winner.
- Includes a watchdog that aborts a memory access stuck in busywait.

Parameters:
- ADDR_WIDTH, 31, word-address width on both the requester and memory sides.
- DATA_WIDTH, 32, data word width.
- TIMEOUT, 255, maximum WAIT cycles before an access is aborted (≥1).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- r0_read / r0_write  in  1 / 1  port-0 read and write request levels.
- r0_address  in  ADDR_WIDTH  port-0 word address.
- r0_writedata  in  DATA_WIDTH  port-0 store data.
- r0_readdata  out  DATA_WIDTH  port-0 load data, registered.
- r0_busywait  out  1  port-0 stall.
- r1_read, r1_write, r1_address, r1_writedata, r1_readdata, r1_busywait  as port 0, for port 1.
- mem_read / mem_write  out  1 / 1  memory strobes, registered.
- mem_address  out  ADDR_WIDTH  memory address, registered.
- mem_writedata  out  DATA_WIDTH  memory store data, registered.
- mem_readdata  in  DATA_WIDTH  memory load data.
- mem_busywait  in  1  memory stall.
- timeout_err  out  1  sticky abort flag; cleared only by reset.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, last_grant=1 so port 0 wins the first tie.
  - All mem_* outputs 0, both rN_readdata 0, timeout_err 0, watchdog counter 0.
  - A reset mid-access abandons the access; no done pulse is produced.
- Request definition: reqN = rN_read | rN_write. If read and write are both high, it is treated as a write: mem_write=1, mem_read=0.
- Busywait: rN_busywait = reqN & ~doneN, combinational. doneN is high only in RESP while granted to N. A requester is therefore released for exactly one cycle and samples data at the closing edge.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requesting: grant the port not equal to last_grant.
  - On grant: latch address, data and strobe into the mem_* registers; set gnt and last_grant; go to ISSUE.
- ISSUE: exactly one cycle; mem_busywait is not sampled, which lets the memory raise it combinationally. Go to WAIT; clear the watchdog.
- WAIT:
  - mem_busywait=0 at an edge: capture mem_readdata into rN_readdata of the granted port (read only); clear mem_read/mem_write; go to RESP.
  - Watchdog counter reaching TIMEOUT: same exit, but readdata forced to 0 and timeout_err set.
- RESP: doneN high for one cycle; go to IDLE.
- Latency: request seen in IDLE at edge k → strobe at k+1 → earliest release at k+3 (memory returns busywait=0 immediately). An uncontended back-to-back request costs 4 cycles.
- Ordering and stability:
  - The grant is fixed from ISSUE through RESP; new or changed requests during this time are ignored.
  - The non-granted port stays stalled.
  - rN_readdata holds its value until the next read completion on that port; writes leave it unchanged.
- Requester protocol: signals must be held stable while busywait is high. Dropping a request mid-access does not cancel the memory operation; the access completes silently.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3), port index constants P_DCACHE=0 and P_IFETCH=1, default widths.
- Sub-module rr_arbiter2: combinational two-way round-robin pick from (req0, req1, last_grant) to (grant_valid, grant_idx). Everything else stays in the top module.

Test Plan:
- Reset, then r0_write addr 0x10 data 0xDEADBEEF with memory stalling 3 cycles → mem_write high for 4 cycles, r0_busywait drops in RESP, mem_write=0 after.
- Follow-up r0_read addr 0x10 → r0_readdata=0xDEADBEEF at the release edge; r1_readdata still 0.
- r0 and r1 both reading in the same cycle from reset → port 0 served first, port 1 next; repeat both → order 0,1,0,1 with r1_busywait high throughout port 0's access.
- r1 read with mem_busywait stuck high, TIMEOUT=4 → released after 4 WAIT cycles, r1_readdata=0, timeout_err=1 and stays 1 on later good accesses.
- Assert reset during WAIT → mem_read=0 and state IDLE immediately; following r1 request is granted (last_grant reset behaviour checked) with no stale done.
- r0_read and r0_write both high, data 0x5A → only mem_write asserted; memory word at that address = 0x5A.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Port 0 is the MEM-stage data port, port 1 the fetch refill port.
package dmem_arbiter_pkg;

   localparam int DEF_ADDR_WIDTH = 31;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_TIMEOUT    = 255;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic P_DCACHE = 1'b0;
   localparam logic P_IFETCH = 1'b1;

   // Watchdog counter width able to hold values up to TIMEOUT.
   function automatic int wd_width(input int t);
      return (t < 2) ? 1 : $clog2(t + 1);
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick; on a tie the port that did not win last time
// is chosen, otherwise the single requester wins.
module rr_arbiter2
   import dmem_arbiter_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_idx
);

   always_comb begin
      grant_valid = req0 | req1;
      grant_idx   = P_DCACHE;
      if (req0 && req1) begin
         grant_idx = ~last_grant;
      end else if (req1) begin
         grant_idx = P_IFETCH;
      end else begin
         grant_idx = P_DCACHE;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter and sequencer sharing one word-addressed data memory between
// the data port and the fetch refill port, with a busywait watchdog.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                  clock,
   input  logic                  reset,

   input  logic                  r0_read,
   input  logic                  r0_write,
   input  logic [ADDR_WIDTH-1:0] r0_address,
   input  logic [DATA_WIDTH-1:0] r0_writedata,
   output logic [DATA_WIDTH-1:0] r0_readdata,
   output logic                  r0_busywait,

   input  logic                  r1_read,
   input  logic                  r1_write,
   input  logic [ADDR_WIDTH-1:0] r1_address,
   input  logic [DATA_WIDTH-1:0] r1_writedata,
   output logic [DATA_WIDTH-1:0] r1_readdata,
   output logic                  r1_busywait,

   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_writedata,
   input  logic [DATA_WIDTH-1:0] mem_readdata,
   input  logic                  mem_busywait,

   output logic                  timeout_err
);

   localparam int WDW = wd_width(TIMEOUT);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

   state_t state;
   state_t state_nx;

   logic gnt;
   logic last_grant;
   logic [WDW-1:0] wd_cnt;

   logic req0;
   logic req1;
   logic grant_valid;
   logic grant_idx;
   logic done0;
   logic done1;

   logic load;
   logic finish;
   logic abort;
   logic wd_clr;
   logic wd_inc;

   logic                  sel_read;
   logic                  sel_write;
   logic [ADDR_WIDTH-1:0] sel_address;
   logic [DATA_WIDTH-1:0] sel_writedata;
   logic [DATA_WIDTH-1:0] rdata_cap;

   assign req0 = r0_read | r0_write;
   assign req1 = r1_read | r1_write;

   assign done0 = (state == RESP) && (gnt == P_DCACHE);
   assign done1 = (state == RESP) && (gnt == P_IFETCH);

   assign r0_busywait = req0 & ~done0;
   assign r1_busywait = req1 & ~done1;

   rr_arbiter2 u_rr (
      .req0        (req0),
      .req1        (req1),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // Request fields of whichever port the arbiter picks this cycle.
   always_comb begin
      sel_read      = r0_read;
      sel_write     = r0_write;
      sel_address   = r0_address;
      sel_writedata = r0_writedata;
      if (grant_idx == P_IFETCH) begin
         sel_read      = r1_read;
         sel_write     = r1_write;
         sel_address   = r1_address;
         sel_writedata = r1_writedata;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      finish   = 1'b0;
      abort    = 1'b0;
      wd_clr   = 1'b0;
      wd_inc   = 1'b0;
      unique case (state)
         IDLE: begin
            if (grant_valid) begin
               load     = 1'b1;
               state_nx = ISSUE;
            end
         end
         // mem_busywait is ignored here so the memory may raise it late.
         ISSUE: begin
            wd_clr   = 1'b1;
            state_nx = WAIT;
         end
         WAIT: begin
            if (!mem_busywait) begin
               finish   = 1'b1;
               state_nx = RESP;
            end else if (wd_cnt == WD_LAST) begin
               abort    = 1'b1;
               state_nx = RESP;
            end else begin
               wd_inc = 1'b1;
            end
         end
         RESP: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign rdata_cap = abort ? '0 : mem_readdata;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         gnt           <= P_DCACHE;
         last_grant    <= P_IFETCH;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         mem_address   <= '0;
         mem_writedata <= '0;
         r0_readdata   <= '0;
         r1_readdata   <= '0;
         timeout_err   <= 1'b0;
         wd_cnt        <= '0;
      end else begin
         if (load) begin
            gnt           <= grant_idx;
            last_grant    <= grant_idx;
            mem_address   <= sel_address;
            mem_writedata <= sel_writedata;
            mem_write     <= sel_write;
            mem_read      <= sel_read & ~sel_write;
         end
         if (finish || abort) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (mem_read) begin
               if (gnt == P_IFETCH) begin
                  r1_readdata <= rdata_cap;
               end else begin
                  r0_readdata <= rdata_cap;
               end
            end
         end
         if (abort) begin
            timeout_err <= 1'b1;
         end
         if (wd_clr) begin
            wd_cnt <= '0;
         end else if (wd_inc) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small stalling memory model.
module tb_dmem_arbiter;

   localparam int AW = 31;
   localparam int DW = 32;

   logic          clock;
   logic          reset;
   logic          r0_read, r0_write;
   logic [AW-1:0] r0_address;
   logic [DW-1:0] r0_writedata, r0_readdata;
   logic          r0_busywait;
   logic          r1_read, r1_write;
   logic [AW-1:0] r1_address;
   logic [DW-1:0] r1_writedata, r1_readdata;
   logic          r1_busywait;
   logic          mem_read, mem_write;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_writedata, mem_readdata;
   logic          mem_busywait;
   logic          timeout_err;

   int passed;
   int total;

   logic [DW-1:0] mem [0:255];
   int  mcnt;
   int  stall;
   bit  stuck;

   dmem_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .TIMEOUT    (4)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .r0_read       (r0_read),
      .r0_write      (r0_write),
      .r0_address    (r0_address),
      .r0_writedata  (r0_writedata),
      .r0_readdata   (r0_readdata),
      .r0_busywait   (r0_busywait),
      .r1_read       (r1_read),
      .r1_write      (r1_write),
      .r1_address    (r1_address),
      .r1_writedata  (r1_writedata),
      .r1_readdata   (r1_readdata),
      .r1_busywait   (r1_busywait),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_writedata (mem_writedata),
      .mem_readdata  (mem_readdata),
      .mem_busywait  (mem_busywait),
      .timeout_err   (timeout_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory stalls for 'stall' cycles after the strobe rises, or forever.
   assign mem_busywait = (mem_read | mem_write) && (stuck || (mcnt < stall));
   assign mem_readdata = mem[mem_address[7:0]];

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mcnt <= 0;
      end else if (mem_read | mem_write) begin
         if (!mem_busywait && mem_write)
            mem[mem_address[7:0]] <= mem_writedata;
         mcnt <= mcnt + 1;
      end else begin
         mcnt <= 0;
      end
   end

   task automatic drop_all();
      r0_read = 0; r0_write = 0; r0_address = '0; r0_writedata = '0;
      r1_read = 0; r1_write = 0; r1_address = '0; r1_writedata = '0;
   endtask

   // Issue one access on port p and wait for its release (cyc=-1 on expiry).
   task automatic access(input int p, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int cyc, output int wc, output int rc);
      cyc = -1; wc = 0; rc = 0;
      if (p == 0) begin
         r0_read = rd; r0_write = wr; r0_address = a; r0_writedata = d;
      end else begin
         r1_read = rd; r1_write = wr; r1_address = a; r1_writedata = d;
      end
      for (int i = 1; i <= 40; i++) begin
         @(negedge clock);
         if (mem_write) wc++;
         if (mem_read) rc++;
         if (((p == 0) ? r0_busywait : r1_busywait) == 1'b0) begin
            cyc = i;
            break;
         end
      end
      if (p == 0) begin
         r0_read = 0; r0_write = 0;
      end else begin
         r1_read = 0; r1_write = 0;
      end
   endtask

   // Wait until either requesting port is released; first=-1 on expiry.
   task automatic wait_rel(output int first, output int cyc);
      first = -1; cyc = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clock);
         if ((r0_read | r0_write) && !r0_busywait) begin
            first = 0; cyc = i; break;
         end
         if ((r1_read | r1_write) && !r1_busywait) begin
            first = 1; cyc = i; break;
         end
      end
   endtask

   task automatic test_reset();
      drop_all();
      stall = 0; stuck = 0;
      reset = 1;
      repeat (3) @(negedge clock);
      total++;
      if ({mem_read, mem_write} !== 2'b00)
         $display("FAIL reset_strobes got %b want 00", {mem_read, mem_write});
      else passed++;
      total++;
      if (r0_readdata !== 32'h0 || r1_readdata !== 32'h0)
         $display("FAIL reset_rdata got %h/%h want 0/0", r0_readdata, r1_readdata);
      else passed++;
      total++;
      if (timeout_err !== 1'b0 || dut.state !== 2'd0)
         $display("FAIL reset_state got err=%b st=%0d want 0/0",
                  timeout_err, dut.state);
      else passed++;
      reset = 0;
      @(negedge clock);
   endtask

   task automatic test_write_stall();
      int cyc, wc, rc;
      stall = 3;
      access(0, 0, 1, 31'h10, 32'hDEADBEEF, cyc, wc, rc);
      total++;
      if (wc !== 4) $display("FAIL wr_strobe_cycles got %0d want 4", wc);
      else passed++;
      total++;
      if (cyc !== 5) $display("FAIL wr_release got %0d want 5", cyc);
      else passed++;
      total++;
      if (mem_write !== 1'b0) $display("FAIL wr_strobe_after got %b want 0", mem_write);
      else passed++;
      @(negedge clock);
      total++;
      if (mem[8'h10] !== 32'hDEADBEEF)
         $display("FAIL wr_mem got %h want deadbeef", mem[8'h10]);
      else passed++;
      total++;
      if (r0_readdata !== 32'h0)
         $display("FAIL wr_keeps_rdata got %h want 0", r0_readdata);
      else passed++;
      stall = 0;
   endtask

   task automatic test_read_back();
      int cyc, wc, rc;
      access(0, 1, 0, 31'h10, 32'h0, cyc, wc, rc);
      total++;
      if (cyc !== 3) $display("FAIL rd_release got %0d want 3", cyc);
      else passed++;
      total++;
      if (r0_readdata !== 32'hDEADBEEF)
         $display("FAIL rd_data got %h want deadbeef", r0_readdata);
      else passed++;
      total++;
      if (r1_readdata !== 32'h0)
         $display("FAIL rd_other_port got %h want 0", r1_readdata);
      else passed++;
      @(negedge clock);
   endtask

   task automatic test_contention();
      int cyc, wc, rc, first;
      access(0, 0, 1, 31'h20, 32'h11112222, cyc, wc, rc);
      access(1, 0, 1, 31'h24, 32'h33334444, cyc, wc, rc);
      @(negedge clock);
      reset = 1;
      @(negedge clock);
      reset = 0;
      @(negedge clock);
      for (int r = 0; r < 2; r++) begin
         r0_read = 1; r0_address = 31'h20;
         r1_read = 1; r1_address = 31'h24;
         wait_rel(first, cyc);
         total++;
         if (first !== 0 || cyc !== 3)
            $display("FAIL rr_first_r%0d got port %0d at %0d want 0 at 3", r, first, cyc);
         else passed++;
         total++;
         if (r1_busywait !== 1'b1 || r0_readdata !== 32'h11112222)
            $display("FAIL rr_stall1_r%0d got bw=%b d=%h want 1/11112222",
                     r, r1_busywait, r0_readdata);
         else passed++;
         r0_read = 0;
         wait_rel(first, cyc);
         total++;
         if (first !== 1 || cyc !== 4 || r1_readdata !== 32'h33334444)
            $display("FAIL rr_second_r%0d got port %0d at %0d d=%h want 1 at 4 33334444",
                     r, first, cyc, r1_readdata);
         else passed++;
         r1_read = 0;
         @(negedge clock);
      end
      // Port 0 keeps requesting after its turn; port 1 must go next.
      r0_read = 1; r0_address = 31'h20;
      r1_read = 1; r1_address = 31'h24;
      wait_rel(first, cyc);
      wait_rel(first, cyc);
      total++;
      if (first !== 1 || r0_busywait !== 1'b1)
         $display("FAIL rr_fair got port %0d bw0=%b want 1/1", first, r0_busywait);
      else passed++;
      drop_all();
      @(negedge clock);
      @(negedge clock);
   endtask

   task automatic test_timeout();
      int cyc, wc, rc;
      stuck = 1;
      access(1, 1, 0, 31'h20, 32'h0, cyc, wc, rc);
      stuck = 0;
      total++;
      if (cyc !== 6 || rc !== 5)
         $display("FAIL to_release got %0d rd=%0d want 6/5", cyc, rc);
      else passed++;
      total++;
      if (r1_readdata !== 32'h0 || timeout_err !== 1'b1)
         $display("FAIL to_result got d=%h err=%b want 0/1", r1_readdata, timeout_err);
      else passed++;
      @(negedge clock);
      access(0, 1, 0, 31'h24, 32'h0, cyc, wc, rc);
      total++;
      if (cyc !== 3 || r0_readdata !== 32'h33334444 || timeout_err !== 1'b1)
         $display("FAIL to_sticky got cyc=%0d d=%h err=%b want 3/33334444/1",
                  cyc, r0_readdata, timeout_err);
      else passed++;
      @(negedge clock);
   endtask

   task automatic test_reset_mid_wait();
      int cyc, wc, rc;
      stuck = 1;
      r1_read = 1; r1_address = 31'h24;
      repeat (3) @(negedge clock);
      total++;
      if (dut.state !== 2'd2 || mem_read !== 1'b1)
         $display("FAIL rst_pre got st=%0d rd=%b want 2/1", dut.state, mem_read);
      else passed++;
      reset = 1;
      #1;
      total++;
      if (mem_read !== 1'b0 || dut.state !== 2'd0 || r1_busywait !== 1'b1)
         $display("FAIL rst_async got rd=%b st=%0d bw=%b want 0/0/1",
                  mem_read, dut.state, r1_busywait);
      else passed++;
      @(negedge clock);
      reset = 0;
      stuck = 0;
      access(1, 1, 0, 31'h24, 32'h0, cyc, wc, rc);
      total++;
      if (cyc !== 3 || r1_readdata !== 32'h33334444 || timeout_err !== 1'b0)
         $display("FAIL rst_after got cyc=%0d d=%h err=%b want 3/33334444/0",
                  cyc, r1_readdata, timeout_err);
      else passed++;
      @(negedge clock);
   endtask

   task automatic test_read_write_both();
      int cyc, wc, rc;
      logic [DW-1:0] keep;
      keep = r0_readdata;
      access(0, 1, 1, 31'h40, 32'h5A, cyc, wc, rc);
      total++;
      if (rc !== 0 || wc !== 2)
         $display("FAIL rw_strobes got rd=%0d wr=%0d want 0/2", rc, wc);
      else passed++;
      @(negedge clock);
      total++;
      if (mem[8'h40] !== 32'h5A || r0_readdata !== keep)
         $display("FAIL rw_mem got m=%h d=%h want 5a/%h", mem[8'h40], r0_readdata, keep);
      else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      reset  = 1;
      drop_all();
      test_reset();
      test_write_stall();
      test_read_back();
      test_contention();
      test_timeout();
      test_reset_mid_wait();
      test_read_write_both();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
